lfsr_stream_gen: RTL

- Parametrised Fibonacci LFSR pattern generator; successor to the fixed-degree single-bit LFSR.
- DEGREE, tap polynomial and output word width are parameters. Each word is OUT_WIDTH consecutive LFSR bits, produced by combinational unrolling.
- Delivers counted bursts over a valid/ready stream to BIST/stimulus consumers. Seed load is guarded.

---
 rtl/lfsr_pkg.sv | 40 ++++
 rtl/lfsr_unroll.sv | 33 +++
 rtl/lfsr_stream_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR stream generator:
//   - lfsr_fsm_e  : burst controller states (IDLE, LOAD, STREAM)
//   - TAPS_D4/16/35 : ready-made maximal-length feedback masks
//   - lfsr_step() : one Fibonacci step on a state of up to LFSR_MAX_W bits
// Tap mask convention: bit i set means polynomial term x^(i+1).
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } lfsr_fsm_e;

    // Widest LFSR the step helper can handle.
    localparam int LFSR_MAX_W = 64;

    localparam logic [3:0]  TAPS_D4  = 4'b1100;         // x^4 + x^3 + 1
    localparam logic [15:0] TAPS_D16 = 16'hB400;        // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [34:0] TAPS_D35 = 35'h4_0000_0002; // x^35 + x^2 + 1

    // One Fibonacci step: shift left, feed the parity of the tapped bits into
    // bit 0. The caller zero-extends its state/taps into the wide argument and
    // truncates the result back to its own degree; the mask keeps the result
    // clean for callers that keep the wide value.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           degree
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (LFSR_MAX_W'(1) << degree) - LFSR_MAX_W'(1);
        fb   = ^(state & taps);
        return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_unroll.sv
// -----------------------------------------------------------------------------
// lfsr_unroll
// Combinational OUT_WIDTH-step unrolling of a Fibonacci LFSR.
// Ports:
//   state      in  DEGREE     current LFSR state
//   word       out OUT_WIDTH  serial bits of the OUT_WIDTH steps, bit 0 first
//   next_state out DEGREE     state after OUT_WIDTH steps
// -----------------------------------------------------------------------------
module lfsr_unroll
    import lfsr_pkg::*;
#(
    parameter int                DEGREE    = 35,
    parameter logic [DEGREE-1:0] TAPS      = TAPS_D35,
    parameter int                OUT_WIDTH = 8
) (
    input  logic [DEGREE-1:0]    state,
    output logic [OUT_WIDTH-1:0] word,
    output logic [DEGREE-1:0]    next_state
);

    always_comb begin
        logic [DEGREE-1:0] cur;
        cur  = state;
        word = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            // The bit shifted out of the top is the serial output of this step.
            word[k] = cur[DEGREE-1];
            cur     = DEGREE'(lfsr_step(LFSR_MAX_W'(cur), LFSR_MAX_W'(TAPS), DEGREE));
        end
        next_state = cur;
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// lfsr_stream_gen
// Parametrised Fibonacci LFSR pattern generator delivering counted bursts of
// OUT_WIDTH-bit words over a valid/ready stream.
//
// Optional feature macro: LFSR_ZERO_SEED_GUARD_EN
//   defined   : an all-zero seed write loads RST_SEED instead and SeedErr_SO
//               pulses for one cycle.
//   undefined : a zero seed is accepted (LFSR locks at zero), SeedErr_SO = 0.
//
// Ports:
//   Clk_CI      in  1          clock, rising edge
//   Rst_RBI     in  1          synchronous active-high reset
//   Start_SI    in  1          start a burst (IDLE only)
//   Len_DI      in  LEN_WIDTH  burst length in words, latched on Start
//   SeedWr_SI   in  1          seed write strobe (IDLE only)
//   Seed_DI     in  DEGREE     seed value
//   Data_DO     out OUT_WIDTH  output word, bit 0 = earliest LFSR bit
//   Valid_SO    out 1          Data_DO valid
//   Ready_SI    in  1          consumer accepts the word
//   Busy_SO     out 1          controller not IDLE
//   Done_SO     out 1          one-cycle pulse at end of burst
//   SeedErr_SO  out 1          one-cycle pulse after a zero seed write
// -----------------------------------------------------------------------------
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int                DEGREE    = 35,
    parameter logic [DEGREE-1:0] TAPS      = TAPS_D35,
    parameter logic [DEGREE-1:0] RST_SEED  = DEGREE'(1),
    parameter int                OUT_WIDTH = 8,
    parameter int                LEN_WIDTH = 16
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    input  logic                 Start_SI,
    input  logic [LEN_WIDTH-1:0] Len_DI,
    input  logic                 SeedWr_SI,
    input  logic [DEGREE-1:0]    Seed_DI,
    output logic [OUT_WIDTH-1:0] Data_DO,
    output logic                 Valid_SO,
    input  logic                 Ready_SI,
    output logic                 Busy_SO,
    output logic                 Done_SO,
    output logic                 SeedErr_SO
);

    lfsr_fsm_e             fsm_q, fsm_d;
    logic [DEGREE-1:0]     state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [DEGREE-1:0]     seed_eff;
    logic [OUT_WIDTH-1:0]  unroll_word;
    logic [DEGREE-1:0]     unroll_next;

    lfsr_unroll #(
        .DEGREE    (DEGREE),
        .TAPS      (TAPS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_unroll (
        .state      (state_q),
        .word       (unroll_word),
        .next_state (unroll_next)
    );

`ifdef LFSR_ZERO_SEED_GUARD_EN
    logic seed_zero;
    logic seed_err_q, seed_err_d;
    assign seed_zero = (Seed_DI == '0);
    // A zero state would lock the LFSR; substitute the reset seed.
    assign seed_eff  = seed_zero ? RST_SEED : Seed_DI;
`else
    assign seed_eff  = Seed_DI;
`endif

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
`ifdef LFSR_ZERO_SEED_GUARD_EN
        seed_err_d  = 1'b0;
`endif
        case (fsm_q)
            IDLE: begin
                // Seed lands in state_q before LOAD runs, so a simultaneous
                // Start generates word 0 from the new seed.
                if (SeedWr_SI) begin
                    state_d = seed_eff;
`ifdef LFSR_ZERO_SEED_GUARD_EN
                    seed_err_d = seed_zero;
`endif
                end
                if (Start_SI) begin
                    if (Len_DI != '0) begin
                        remaining_d = Len_DI;
                        fsm_d       = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                data_d  = unroll_word;
                state_d = unroll_next;
                valid_d = 1'b1;
                fsm_d   = STREAM;
            end
            STREAM: begin
                if (valid_q && Ready_SI) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        fsm_d   = IDLE;
                    end else begin
                        // Refill in the handshake cycle for 1 word/cycle.
                        data_d  = unroll_word;
                        state_d = unroll_next;
                    end
                end
            end
            default: begin
                fsm_d   = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            fsm_q       <= IDLE;
            state_q     <= RST_SEED;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

`ifdef LFSR_ZERO_SEED_GUARD_EN
    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            seed_err_q <= 1'b0;
        end else begin
            seed_err_q <= seed_err_d;
        end
    end
    assign SeedErr_SO = seed_err_q;
`else
    assign SeedErr_SO = 1'b0;
`endif

    assign Data_DO  = data_q;
    assign Valid_SO = valid_q;
    assign Busy_SO  = (fsm_q != IDLE);
    assign Done_SO  = done_q;

endmodule
